vga_pixel_pipeline: RTL and testbench
=====================================

// Module: vga_pixel_pipeline
// PURPOSE
// - Downstream stage of the H/V sync generators. Consumes the horizontal/vertical counter values and raw
//   sync levels, finds the active-video window, and issues linear framebuffer read addresses.
// - Delays the syncs and the active flag to match the framebuffer read latency, then drives
//   time-aligned RGB, hsync and vsync to the VGA pins.
// - RGB is forced to zero outside the active window.
// PARAMETERS
// - COUNTER_SIZE    11    width of the h/v counter inputs
// - H_ACTIVE_START  296   first active h count
// - H_ACTIVE        1024  active pixels per line
// - V_ACTIVE_START  35    first active v count
// - V_ACTIVE        768   active lines per frame
// - FB_ADDR_WIDTH   20    framebuffer address width; must hold H_ACTIVE*V_ACTIVE-1
// - FB_LATENCY      2     pixel ticks from fb_read to valid fb_rdata; range 1..8
// - COLOR_BITS      4     bits per colour channel
// PORTS
// - control_clock  in   1                clock, rising edge
// - reset          in   1                asynchronous, active-high
// - pixel_enable   in   1                one-cycle pixel tick; all pipeline state advances only on it
// - counter_out_hsync in COUNTER_SIZE    horizontal count from the H sync generator
// - counter_out_vsync in COUNTER_SIZE    vertical count from the V sync generator
// - h_sync_in      in   1                raw hsync level
// - v_sync_in      in   1                raw vsync level
// - fb_read        out  1                framebuffer read strobe, one control_clock cycle wide
// - fb_addr        out  FB_ADDR_WIDTH    linear read address
// - fb_rdata       in   3*COLOR_BITS     {R,G,B} read data
// - vga_r/vga_g/vga_b out COLOR_BITS     pixel colour
// - h_sync         out  1                aligned hsync
// - v_sync         out  1                aligned vsync
// - display_enable out  1                aligned active-video flag
// - frame_start    out  1                one-tick pulse, aligned with the first active pixel of a frame
// BEHAVIOUR
// - Reset: all outputs are 0; the address counter and all delay stages clear.
// - Reset acts mid-frame. After release, output is blanked until the delay line refills
//   (FB_LATENCY+1 ticks). The address counter is valid only from the next frame start.
// - Stage 0, on each pixel_enable:
//   - Register the counters and syncs.
//   - active = (hc in [H_ACTIVE_START, H_ACTIVE_START+H_ACTIVE)) && (vc in [V_ACTIVE_START, V_ACTIVE_START+V_ACTIVE)).
// - Read request: fb_read = 1 for the single clock following a pixel_enable that sampled active=1.
//   fb_addr holds its value until the next request.
// - Address counter:
//   - Cleared to 0 when pixel_enable samples hc==0 && vc==0.
//   - Increments by 1 after each issued read, with no per-line reload.
//   - Rolls from H_ACTIVE*V_ACTIVE-1 to 0. This rollover is never reached within a legal frame.
//   - Counter clear and an active pixel on the same tick: clear wins.
// - Delay line: FB_LATENCY-deep shift of {h_sync, v_sync, active, first} that advances only on pixel_enable.
// - Output stage, on pixel_enable:
//   - Outputs are registered and take the delay-line tail.
//   - If the delayed active=1: vga_r/g/b = fb_rdata slices, R in the MSBs. Otherwise RGB = 0.
// - Latency: every output reflects input sampled FB_LATENCY+1 pixel ticks earlier, with identical
//   latency for sync and colour.
// - first flag = active && hc==H_ACTIVE_START && vc==V_ACTIVE_START.
//   frame_start is high for exactly one pixel_enable interval.
// - pixel_enable held low: every output and state holds. No read is issued.
// - Counter values beyond the active window, up to the max of COUNTER_SIZE, are treated as blanking.
// STRUCTURE
// - Shared package vga_timing_pkg holds:
//   - default timing constants (H/V active start and size, totals);
//   - COUNTER_SIZE;
//   - the typedef of the packed RGB pixel.
// - One sub-module: vga_delay_line, a parameterised width × depth shift register with enable.
// - The window compare, address counter and output registers stay in this module.
// TESTING
// - Overrides for all tests: H_ACTIVE_START=4, H_ACTIVE=8, V_ACTIVE_START=2, V_ACTIVE=4, FB_LATENCY=2.
//   pixel_enable every 2nd clock.
// - Full frame, memory model returns data=addr: fb_addr runs 0..31, one fb_read per active pixel.
//   Output RGB equals the address, 3 ticks after the matching counter sample. Blanking RGB=0.
// - Sync alignment: h_sync_in toggling at hc=0/hc=2. h_sync output shows the same pattern delayed
//   by exactly 3 ticks. Same check for v_sync.
// - frame_start: exactly one pulse per frame, coincident with the display_enable rising edge at hc=4, vc=2.
// - Stall: hold pixel_enable low for 10 clocks mid-line. No fb_read, outputs frozen.
//   The sequence resumes without skipped or duplicated addresses.
// - Reset mid-line at fb_addr=13:
//   - all outputs are 0 asynchronously;
//   - after release, RGB stays 0 for ≥3 ticks;
//   - the next frame starts at fb_addr=0.
// - Out-of-range counters (hc=2000, vc=2000): display_enable=0, no fb_read.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and the packed RGB pixel type used by the pixel pipeline.
package vga_timing_pkg;

  localparam int unsigned COUNTER_SIZE   = 11;
  localparam int unsigned H_ACTIVE_START = 296;
  localparam int unsigned H_ACTIVE       = 1024;
  localparam int unsigned H_TOTAL        = 1344;
  localparam int unsigned V_ACTIVE_START = 35;
  localparam int unsigned V_ACTIVE       = 768;
  localparam int unsigned V_TOTAL        = 806;
  localparam int unsigned FB_ADDR_WIDTH  = 20;
  localparam int unsigned FB_LATENCY     = 2;
  localparam int unsigned COLOR_BITS     = 4;

  typedef struct packed {
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register that advances only when en is high.
module vga_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_pipeline.sv
// Active-window detection, linear framebuffer addressing and latency-matched RGB/sync output stage.
module vga_pixel_pipeline #(
  parameter int unsigned COUNTER_SIZE   = vga_timing_pkg::COUNTER_SIZE,
  parameter int unsigned H_ACTIVE_START = vga_timing_pkg::H_ACTIVE_START,
  parameter int unsigned H_ACTIVE       = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE_START = vga_timing_pkg::V_ACTIVE_START,
  parameter int unsigned V_ACTIVE       = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned FB_ADDR_WIDTH  = vga_timing_pkg::FB_ADDR_WIDTH,
  parameter int unsigned FB_LATENCY     = vga_timing_pkg::FB_LATENCY,
  parameter int unsigned COLOR_BITS     = vga_timing_pkg::COLOR_BITS
) (
  input  logic                      control_clock,
  input  logic                      reset,
  input  logic                      pixel_enable,
  input  logic [COUNTER_SIZE-1:0]   counter_out_hsync,
  input  logic [COUNTER_SIZE-1:0]   counter_out_vsync,
  input  logic                      h_sync_in,
  input  logic                      v_sync_in,
  output logic                      fb_read,
  output logic [FB_ADDR_WIDTH-1:0]  fb_addr,
  input  logic [3*COLOR_BITS-1:0]   fb_rdata,
  output logic [COLOR_BITS-1:0]     vga_r,
  output logic [COLOR_BITS-1:0]     vga_g,
  output logic [COLOR_BITS-1:0]     vga_b,
  output logic                      h_sync,
  output logic                      v_sync,
  output logic                      display_enable,
  output logic                      frame_start
);

  localparam int unsigned CW      = COUNTER_SIZE + 1;
  localparam int unsigned FB_LAST = H_ACTIVE * V_ACTIVE - 1;
  localparam int unsigned TAP_W   = 4;

  // One extra bit so window end (start + size) never wraps in the compare.
  logic [CW-1:0] hc_x;
  logic [CW-1:0] vc_x;
  logic          active_c;
  logic          first_c;
  logic          origin_c;

  assign hc_x     = {1'b0, counter_out_hsync};
  assign vc_x     = {1'b0, counter_out_vsync};
  assign active_c = (hc_x >= CW'(H_ACTIVE_START)) && (hc_x < CW'(H_ACTIVE_START + H_ACTIVE)) &&
                    (vc_x >= CW'(V_ACTIVE_START)) && (vc_x < CW'(V_ACTIVE_START + V_ACTIVE));
  assign first_c  = active_c && (hc_x == CW'(H_ACTIVE_START)) && (vc_x == CW'(V_ACTIVE_START));
  assign origin_c = (counter_out_hsync == '0) && (counter_out_vsync == '0);

  // Stage 0: {hsync, vsync, active, first}
  logic [TAP_W-1:0] s0_q;
  logic [TAP_W-1:0] tail;

  always_ff @(posedge control_clock or posedge reset) begin
    if (reset) begin
      s0_q <= '0;
    end else if (pixel_enable) begin
      s0_q <= {h_sync_in, v_sync_in, active_c, first_c};
    end
  end

  // Read request and address counter; origin clear takes priority over increment.
  logic [FB_ADDR_WIDTH-1:0] addr_cnt;

  always_ff @(posedge control_clock or posedge reset) begin
    if (reset) begin
      fb_read  <= 1'b0;
      fb_addr  <= '0;
      addr_cnt <= '0;
    end else begin
      fb_read <= pixel_enable && active_c;
      if (pixel_enable) begin
        if (active_c) fb_addr <= origin_c ? '0 : addr_cnt;
        if (origin_c) begin
          addr_cnt <= '0;
        end else if (active_c) begin
          addr_cnt <= (addr_cnt == FB_ADDR_WIDTH'(FB_LAST)) ? '0 : addr_cnt + FB_ADDR_WIDTH'(1);
        end
      end
    end
  end

  vga_delay_line #(
    .WIDTH (TAP_W),
    .DEPTH (FB_LATENCY)
  ) u_delay (
    .clk  (control_clock),
    .rst  (reset),
    .en   (pixel_enable),
    .din  (s0_q),
    .dout (tail)
  );

  // Output stage: colour arrives with the delayed active flag, blanked outside the window.
  always_ff @(posedge control_clock or posedge reset) begin
    if (reset) begin
      h_sync         <= 1'b0;
      v_sync         <= 1'b0;
      display_enable <= 1'b0;
      frame_start    <= 1'b0;
      vga_r          <= '0;
      vga_g          <= '0;
      vga_b          <= '0;
    end else if (pixel_enable) begin
      h_sync         <= tail[3];
      v_sync         <= tail[2];
      display_enable <= tail[1];
      frame_start    <= tail[0];
      if (tail[1]) begin
        {vga_r, vga_g, vga_b} <= fb_rdata;
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Directed bench for vga_pixel_pipeline on a small 14x8 raster with an 8x4 active window.
module tb_vga_pixel_pipeline;
  import vga_timing_pkg::*;

  localparam int unsigned CS = 11;
  localparam int unsigned AW = 20;
  localparam int unsigned CB = 4;
  localparam int HT = 14;
  localparam int VT = 8;

  logic          clk;
  logic          reset;
  logic          pixel_enable;
  logic [CS-1:0] counter_out_hsync;
  logic [CS-1:0] counter_out_vsync;
  logic          h_sync_in;
  logic          v_sync_in;
  logic          fb_read;
  logic [AW-1:0] fb_addr;
  logic [3*CB-1:0] fb_rdata;
  logic [CB-1:0] vga_r;
  logic [CB-1:0] vga_g;
  logic [CB-1:0] vga_b;
  logic          h_sync;
  logic          v_sync;
  logic          display_enable;
  logic          frame_start;

  vga_pixel_pipeline #(
    .COUNTER_SIZE   (CS),
    .H_ACTIVE_START (4),
    .H_ACTIVE       (8),
    .V_ACTIVE_START (2),
    .V_ACTIVE       (4),
    .FB_ADDR_WIDTH  (AW),
    .FB_LATENCY     (2),
    .COLOR_BITS     (CB)
  ) dut (
    .control_clock     (clk),
    .reset             (reset),
    .pixel_enable      (pixel_enable),
    .counter_out_hsync (counter_out_hsync),
    .counter_out_vsync (counter_out_vsync),
    .h_sync_in         (h_sync_in),
    .v_sync_in         (v_sync_in),
    .fb_read           (fb_read),
    .fb_addr           (fb_addr),
    .fb_rdata          (fb_rdata),
    .vga_r             (vga_r),
    .vga_g             (vga_g),
    .vga_b             (vga_b),
    .h_sync            (h_sync),
    .v_sync            (v_sync),
    .display_enable    (display_enable),
    .frame_start       (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer model: data = address, valid two pixel ticks after the read strobe.
  logic [11:0] m0, m1, rdata_q;
  always_ff @(posedge clk) begin
    if (fb_read) m0 <= 12'(fb_addr);
    if (pixel_enable) begin
      m1      <= m0;
      rdata_q <= m1;
    end
  end
  assign fb_rdata = rdata_q;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
    rgb_t rgb;
  } out_t;

  out_t pipe [3];
  out_t last_exp;
  int tests = 0;
  int fails = 0;
  int maddr = 0;
  int post_rst = 0;
  int dut_reads, dut_first, dut_last, fs_count;
  bit rst_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input out_t e);
    check({tag, "_h_sync"}, 32'(h_sync), 32'(e.hs));
    check({tag, "_v_sync"}, 32'(v_sync), 32'(e.vs));
    check({tag, "_display_enable"}, 32'(display_enable), 32'(e.de));
    check({tag, "_frame_start"}, 32'(frame_start), 32'(e.fs));
    check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fb_read"}, 32'(fb_read), 32'd0);
    check({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
    check({tag, "_outputs"}, 32'({vga_r, vga_g, vga_b, h_sync, v_sync, display_enable, frame_start}), 32'd0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    maddr    = 0;
    post_rst = 0;
  endtask

  // One pixel tick starting at a falling edge; outputs sampled at the following falling edge.
  task automatic tick(input int hc, input int vc);
    out_t e;
    out_t now;
    logic act;
    counter_out_hsync = CS'(hc);
    counter_out_vsync = CS'(vc);
    h_sync_in         = (hc < 2);
    v_sync_in         = (vc < 1);
    pixel_enable      = 1'b1;
    act = (hc >= 4) && (hc < 12) && (vc >= 2) && (vc < 6);
    if (hc == 0 && vc == 0) maddr = 0;
    e.hs  = h_sync_in;
    e.vs  = v_sync_in;
    e.de  = act;
    e.fs  = act && hc == 4 && vc == 2;
    e.rgb = act ? rgb_t'(12'(maddr)) : '0;
    now     = pipe[2];
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = e;
    @(negedge clk);
    pixel_enable = 1'b0;
    check("fb_read", 32'(fb_read), 32'(act));
    if (act) begin
      check("fb_addr", 32'(fb_addr), 32'(maddr));
      maddr = (maddr + 1) % 32;
    end
    if (fb_read) begin
      if (dut_reads == 0) dut_first = int'(fb_addr);
      dut_last = int'(fb_addr);
      dut_reads++;
    end
    check_outputs("pix", now);
    if (post_rst < 3) check("rgb_blank_after_reset", 32'({vga_r, vga_g, vga_b}), 32'd0);
    post_rst++;
    fs_count += int'(frame_start);
    last_exp = now;
    @(negedge clk);
  endtask

  task automatic run_frame(input int stall_hc, input int stall_vc, input bit do_reset, input bit stats);
    dut_reads = 0;
    dut_first = -1;
    dut_last  = -1;
    fs_count  = 0;
    for (int vc = 0; vc < VT; vc++) begin
      for (int hc = 0; hc < HT; hc++) begin
        tick(hc, vc);
        if (hc == stall_hc && vc == stall_vc) begin
          repeat (10) begin
            @(negedge clk);
            check("stall_fb_read", 32'(fb_read), 32'd0);
          end
          check_outputs("stall_frozen", last_exp);
        end
        if (do_reset && !rst_done && dut_last == 13) begin
          rst_done = 1'b1;
          #2 reset = 1'b1;
          #1 check_all_zero("async_reset");
          @(negedge clk);
          reset = 1'b0;
          clear_model();
        end
      end
    end
    if (stats) begin
      check("frame_reads", 32'(dut_reads), 32'd32);
      check("frame_first_addr", 32'(dut_first), 32'd0);
      check("frame_last_addr", 32'(dut_last), 32'd31);
      check("frame_start_count", 32'(fs_count), 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset             = 1'b0;
    pixel_enable      = 1'b0;
    counter_out_hsync = '0;
    counter_out_vsync = '0;
    h_sync_in         = 1'b0;
    v_sync_in         = 1'b0;
    clear_model();
    #1 reset = 1'b1;
    #1 check_all_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Clean frame: addresses 0..31, data=addr, sync alignment, single frame_start
    run_frame(-1, -1, 1'b0, 1'b1);
    // Stall mid-line for 10 clocks
    run_frame(7, 3, 1'b0, 1'b1);
    // Reset once fb_addr reaches 13, then a full frame starting from 0
    run_frame(-1, -1, 1'b1, 1'b0);
    check("reset_was_applied", 32'(rst_done), 32'd1);
    run_frame(-1, -1, 1'b0, 1'b1);

    // Out-of-range counters are blanking
    tick(2000, 2000);
    tick(2000, 3);
    tick(5, 2000);
    tick(1, 7);
    tick(1, 7);
    tick(1, 7);
    check("oor_display_enable", 32'(display_enable), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
